// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C write sequencer: FSM state encoding,
// FINISH hold length and the address-byte build rule.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR_TX,
        ADDR_HOLD,
        DATA_TX,
        DATA_HOLD,
        STOP,
        FINISH
    } seq_state_t;

    localparam int unsigned FINISH_HOLD = 20;

    // First byte on the bus: 7-bit slave address followed by the R/W bit (0 = write).
    function automatic logic [7:0] addr_byte(input logic [6:0] addr);
        return {addr, 1'b0};
    endfunction

endpackage

// File: rtl/i2c_write_seq_if.sv
// Command and write-data handshake bundle between a host and the I2C write sequencer.
interface i2c_write_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready
    );

endinterface

// File: rtl/i2c_seq_fifo.sv
// Synchronous 8-bit FIFO with first-word fall-through read data and an occupancy count.
module i2c_seq_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is not reset; the pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_write_seq.sv
// Drives an I2C_Master through START, address byte, FIFO data bytes, STOP and a FINISH hold.
// Define I2C_WRITE_SEQ_TIMEOUT_EN to add a per-byte watchdog that aborts to STOP and flags err.
module i2c_write_seq
    import i2c_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic           clk,
    input  logic           reset,
    i2c_write_seq_if.slave bus,
    output logic           I2C_En,
    output logic           I2C_Start,
    output logic           I2C_Stop,
    output logic [7:0]     tx_data,
    input  logic           ready,
    input  logic           tx_done,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYC == 0) begin : g_bad_param
        $error("i2c_write_seq: FIFO_DEPTH must be a power of two in 2..16, TIMEOUT_CYC nonzero");
    end

    seq_state_t    state, state_nxt;
    logic [3:0]    byte_cnt, byte_cnt_nxt;
    logic [4:0]    fin_cnt, fin_cnt_nxt;
    logic [7:0]    tx_data_nxt;
    logic          done_nxt, err_nxt;
    logic          pop;
    logic [7:0]    fifo_rd;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          len_bad, cmd_rdy, accept, in_tx;
    logic          tmo_hit, timed_out;

    i2c_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.wr_valid),
        .wr_data (bus.wr_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Illegal lengths are still accepted so the host always gets an answer (an err pulse).
    assign len_bad       = (bus.cmd_len == 4'd0) || (32'(bus.cmd_len) > FIFO_DEPTH);
    assign cmd_rdy       = reset && (state == IDLE) && (len_bad || (5'(fifo_count) >= 5'(bus.cmd_len)));
    assign accept        = bus.cmd_valid && cmd_rdy;
    assign bus.cmd_ready = cmd_rdy;
    assign bus.wr_ready  = !fifo_full;

    assign in_tx     = (state == ADDR_TX) || (state == DATA_TX);
    assign busy      = (state != IDLE);
    assign I2C_En    = (state != IDLE);
    assign I2C_Start = (state == START);
    assign I2C_Stop  = (state == STOP);

`ifdef I2C_WRITE_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            if ((state_nxt == ADDR_TX || state_nxt == DATA_TX) && state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (in_tx) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            if (state == IDLE) begin
                timed_out <= 1'b0;
            end else if (in_tx && !tx_done && tmo_hit) begin
                timed_out <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            fin_cnt  <= '0;
            tx_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            fin_cnt  <= fin_cnt_nxt;
            tx_data  <= tx_data_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        fin_cnt_nxt  = fin_cnt;
        tx_data_nxt  = tx_data;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        pop          = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (len_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        byte_cnt_nxt = bus.cmd_len;
                        tx_data_nxt  = addr_byte(bus.cmd_addr);
                        state_nxt    = START;
                    end
                end
            end
            START: state_nxt = ADDR_TX;
            // tx_done wins over a same-cycle ready; ready is looked at again in *_HOLD.
            ADDR_TX: begin
                if (tx_done)      state_nxt = ADDR_HOLD;
                else if (tmo_hit) state_nxt = STOP;
            end
            DATA_TX: begin
                if (tx_done)      state_nxt = DATA_HOLD;
                else if (tmo_hit) state_nxt = STOP;
            end
            ADDR_HOLD, DATA_HOLD: begin
                if (ready) begin
                    if (byte_cnt != 4'd0) begin
                        pop          = 1'b1;
                        tx_data_nxt  = fifo_rd;
                        byte_cnt_nxt = byte_cnt - 1'b1;
                        state_nxt    = DATA_TX;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                fin_cnt_nxt = '0;
                state_nxt   = FINISH;
            end
            FINISH: begin
                if (fin_cnt == 5'(FINISH_HOLD - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = !timed_out;
                    err_nxt   = timed_out;
                end else begin
                    fin_cnt_nxt = fin_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // After a watchdog abort, drain the unsent bytes of this command one per cycle.
        if (timed_out && (state == STOP || state == FINISH) && byte_cnt != 4'd0) begin
            pop          = 1'b1;
            byte_cnt_nxt = byte_cnt - 1'b1;
        end
    end

endmodule
